// File: rtl/memory_responder.sv
// Unified instruction/data memory responder: single-port word storage with
// req/wr handshake, configurable read latency and a one-cycle completion ack.
module memory_responder #(
  parameter int AWIDTH       = 5,
  parameter int DWIDTH       = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [AWIDTH-1:0] address,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata,
  output logic              ack,
  output logic              busy
);

  localparam int         DEPTH  = 2 ** AWIDTH;
  localparam logic [2:0] LAT_M1 = 3'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;
  logic [DWIDTH-1:0]   mem_q [DEPTH];
  logic                mem_we_s;
  logic [AWIDTH-1:0]   mem_waddr_s;
  logic [DWIDTH-1:0]   mem_wdata_s;

  // Next-state, storage write port and output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rdata_d     = rdata_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = addr_q;
    mem_wdata_s = wdata;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d = address;
          if (wr) begin
            // Writes commit at the sample edge; only the ack is deferred.
            mem_we_s    = 1'b1;
            mem_waddr_s = address;
            state_d     = S_DONE;
          end else if (READ_LATENCY == 1) begin
            rdata_d = mem_q[address];
            state_d = S_DONE;
          end else begin
            cnt_d   = LAT_M1;
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d = mem_q[addr_q];
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Outputs are registered copies of the upcoming state's decode.
    ack_d  = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // State, outputs and storage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= {AWIDTH{1'b0}};
      rdata_q <= {DWIDTH{1'b0}};
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DWIDTH{1'b0}};
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      if (mem_we_s) begin
        mem_q[mem_waddr_s] <= mem_wdata_s;
      end
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_memory_responder.sv
// Randomised self-checking bench for memory_responder; three instances with
// read latencies 2, 1 and 7 checked against an array-based reference model.
module tb_memory_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_s   [3];
  logic       wr_s    [3];
  logic [4:0] addr_s  [3];
  logic [7:0] wdata_s [3];
  logic [7:0] rdata0, rdata1, rdata2;
  logic       ack0, ack1, ack2;
  logic       busy0, busy1, busy2;

  int tests_run    = 0;
  int tests_failed = 0;

  int         lat_of [3] = '{2, 1, 7};
  logic [7:0] model_mem [3][32];
  logic [7:0] model_rd  [3];

  memory_responder #(.AWIDTH(5), .DWIDTH(8), .READ_LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req(req_s[0]), .wr(wr_s[0]), .address(addr_s[0]),
    .wdata(wdata_s[0]), .rdata(rdata0), .ack(ack0), .busy(busy0));
  memory_responder #(.AWIDTH(5), .DWIDTH(8), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req(req_s[1]), .wr(wr_s[1]), .address(addr_s[1]),
    .wdata(wdata_s[1]), .rdata(rdata1), .ack(ack1), .busy(busy1));
  memory_responder #(.AWIDTH(5), .DWIDTH(8), .READ_LATENCY(7)) u_l7 (
    .clk(clk), .rst(rst), .req(req_s[2]), .wr(wr_s[2]), .address(addr_s[2]),
    .wdata(wdata_s[2]), .rdata(rdata2), .ack(ack2), .busy(busy2));

  initial forever #5 clk = ~clk;

  function automatic logic get_ack(input int i);
    if (i == 0) return ack0;
    else if (i == 1) return ack1;
    else return ack2;
  endfunction

  function automatic logic get_busy(input int i);
    if (i == 0) return busy0;
    else if (i == 1) return busy1;
    else return busy2;
  endfunction

  function automatic logic [7:0] get_rdata(input int i);
    if (i == 0) return rdata0;
    else if (i == 1) return rdata1;
    else return rdata2;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      model_rd[i] = 8'h00;
      for (int j = 0; j < 32; j++) model_mem[i][j] = 8'h00;
    end
  endfunction

  // One complete access on instance i; hold keeps req asserted (as a write of 0) until ack.
  task automatic access(input int i, input bit w, input logic [4:0] a,
                        input logic [7:0] d, input bit hold, input string name);
    int n;
    bit seen;
    int expl;
    expl = w ? 1 : lat_of[i];
    @(negedge clk);
    req_s[i] = 1'b1; wr_s[i] = w; addr_s[i] = a; wdata_s[i] = d;
    if (w) model_mem[i][a] = d;
    else   model_rd[i] = model_mem[i][a];
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (hold) begin
        wr_s[i] = 1'b1; wdata_s[i] = 8'h00;
      end else begin
        req_s[i] = 1'b0;
      end
      if (get_ack(i) === 1'b1) begin
        seen = 1'b1;
      end else begin
        tests_run++;
        if (get_busy(i) !== 1'b1) begin
          tests_failed++;
          $display("FAIL %s busy_in_flight: inst %0d got %b expected 1", name, i, get_busy(i));
        end
      end
    end
    req_s[i] = 1'b0;
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL %s ack_timeout: inst %0d no ack within 20 cycles", name, i);
    end else if (n != expl) begin
      tests_failed++;
      $display("FAIL %s latency: inst %0d got %0d expected %0d", name, i, n, expl);
    end
    tests_run++;
    if (get_busy(i) !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s busy_at_ack: inst %0d got %b expected 1", name, i, get_busy(i));
    end
    tests_run++;
    if (get_rdata(i) !== model_rd[i]) begin
      tests_failed++;
      $display("FAIL %s rdata: inst %0d got %h expected %h", name, i, get_rdata(i), model_rd[i]);
    end
    @(negedge clk);
    tests_run++;
    if (get_ack(i) !== 1'b0 || get_busy(i) !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s back_to_idle: inst %0d ack=%b busy=%b expected 0/0", name, i, get_ack(i), get_busy(i));
    end
  endtask

  task automatic check_all_cleared(input string name);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (get_ack(i) !== 1'b0 || get_busy(i) !== 1'b0 || get_rdata(i) !== 8'h00) begin
        tests_failed++;
        $display("FAIL %s: inst %0d ack=%b busy=%b rdata=%h expected 0/0/00",
                 name, i, get_ack(i), get_busy(i), get_rdata(i));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = 5'd0; wdata_s[i] = 8'h00;
    end
    model_reset();
    #1;
    check_all_cleared("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all_cleared("after_reset_release");
  endtask

  task automatic test_write_read();
    access(0, 1'b1, 5'h03, 8'hA5, 1'b0, "wr_a5");
    access(0, 1'b0, 5'h03, 8'h00, 1'b0, "rd_a5");
  endtask

  task automatic test_no_alias();
    for (int i = 0; i < 3; i++) begin
      access(i, 1'b1, 5'h00, 8'h11, 1'b0, "wr_lo");
      access(i, 1'b1, 5'h1F, 8'hEE, 1'b0, "wr_hi");
      access(i, 1'b0, 5'h00, 8'h00, 1'b0, "rd_lo");
      access(i, 1'b0, 5'h1F, 8'h00, 1'b0, "rd_hi");
    end
  endtask

  task automatic test_ignore_busy();
    // Held write-of-zero during WAIT/DONE must not reach storage.
    access(0, 1'b0, 5'h03, 8'h00, 1'b1, "rd_held");
    access(0, 1'b0, 5'h03, 8'h00, 1'b0, "rd_after_held");
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all_cleared("reset_mid_run");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    access(0, 1'b0, 5'h07, 8'h00, 1'b0, "rd_07_after_reset");
    access(0, 1'b0, 5'h03, 8'h00, 1'b0, "rd_03_cleared");
  endtask

  task automatic test_reset_during_wait();
    bit acked;
    access(2, 1'b1, 5'h04, 8'h5A, 1'b0, "wr_5a");
    access(2, 1'b0, 5'h04, 8'h00, 1'b0, "rd_5a");
    @(negedge clk);
    req_s[2] = 1'b1; wr_s[2] = 1'b0; addr_s[2] = 5'h04;
    @(negedge clk);
    req_s[2] = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL wait_before_reset: busy got %b expected 1", busy2);
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all_cleared("reset_in_wait");
    acked = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ack2 !== 1'b0) acked = 1'b1;
    end
    tests_run++;
    if (acked) begin
      tests_failed++;
      $display("FAIL dropped_read_ack: got ack pulse expected none");
    end
    access(2, 1'b0, 5'h04, 8'h00, 1'b0, "rd_after_wait_reset");
  endtask

  task automatic test_latency_variants();
    for (int i = 1; i < 3; i++) begin
      access(i, 1'b1, 5'h10, 8'h3C, 1'b0, "wr_3c");
      access(i, 1'b0, 5'h10, 8'h00, 1'b0, "rd_3c");
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      int i;
      i = $urandom_range(0, 2);
      access(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             8'($urandom_range(0, 255)), 1'b0, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] a;
    logic [7:0] d;
    a = 5'($urandom_range(0, 31));
    d = 8'($urandom_range(1, 255));
    @(negedge clk);
    req_s[0] = 1'b1; wr_s[0] = 1'b1; addr_s[0] = a; wdata_s[0] = d;
    model_mem[0][a] = d;
    @(negedge clk);
    tests_run++;
    if (ack0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_write_ack: got %b expected 1", ack0);
    end
    wr_s[0] = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy0 !== 1'b0 || ack0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle_gap: busy=%b ack=%b expected 0/0", busy0, ack0);
    end
    @(negedge clk);
    req_s[0] = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ack0 !== 1'b1 || rdata0 !== model_mem[0][a]) begin
      tests_failed++;
      $display("FAIL b2b_read: ack=%b rdata=%h expected 1/%h", ack0, rdata0, model_mem[0][a]);
    end
    model_rd[0] = model_mem[0][a];
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_no_alias();
    test_ignore_busy();
    test_reset_mid_run();
    test_reset_during_wait();
    test_latency_variants();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
